fir_stream_filter: RTL

- Parametrised direct-form FIR filter. Successor to the fixed 3-tap, 8-bit filter.
- Fixed-point two's complement, Q(WL-WF).WF. Default Q2.6.
- Generalised in tap count and word length. Adds runtime coefficient load, valid handshake, flush, round-to-nearest and saturation with a flag.
- Sits between a sample source and downstream DSP blocks.

---
 rtl/fir_pkg.sv | 37 +++
 rtl/fx_round_sat.sv | 51 +++++
 rtl/fir_stream_filter.sv | 115 +++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared fixed-point helpers for the streaming FIR filter.
//   clog2     : ceiling log2, returns 0 for values <= 1
//   acc_w     : width of the tap-sum accumulator (never overflows)
//   one_q     : the value 1.0 in a format with wf fractional bits
//   sat_max/  : signed range limits of a wl-bit output word
//   sat_min
package fir_pkg;

  localparam int DEF_WL = 8;
  localparam int DEF_WF = 6;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Full-precision products are 2*wl bits wide. Summing taps of them needs
  // clog2(taps) extra bits of headroom.
  function automatic int acc_w(input int wl, input int taps);
    return 2 * wl + clog2(taps);
  endfunction

  function automatic longint one_q(input int wf);
    return longint'(1) << wf;
  endfunction

  function automatic longint sat_max(input int wl);
    return (longint'(1) << (wl - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int wl);
    return -(longint'(1) << (wl - 1));
  endfunction

endpackage

// File: rtl/fx_round_sat.sv
// Combinational requantiser: round half up, arithmetic shift right by WF,
// then saturate to a WL-bit signed word.
//   din  : signed value with 2*WF fractional bits (IW bits wide)
//   dout : signed result with WF fractional bits (WL bits wide)
//   clip : 1 when the rounded value was outside the WL-bit range
// WF must be at least 1.
module fx_round_sat
  import fir_pkg::*;
#(
  parameter int IW = 18,
  parameter int WF = 6,
  parameter int WL = 8
) (
  input  logic signed [IW-1:0] din,
  output logic signed [WL-1:0] dout,
  output logic                 clip
);

  // One extra bit so adding the rounding constant can never wrap.
  localparam int RW = IW + 1;
  localparam int SW = RW - WF;
  localparam logic signed [SW-1:0] MAX_V = SW'(sat_max(WL));
  localparam logic signed [SW-1:0] MIN_V = SW'(sat_min(WL));

  function automatic logic signed [SW-1:0] round_shift(input logic signed [IW-1:0] v);
    logic signed [RW-1:0] t;
    t = RW'(v);
    t = t + (RW'(1) << (WF - 1));
    return t[RW-1:WF];
  endfunction

  // Returns {clip, value}.
  function automatic logic [WL:0] saturate(input logic signed [SW-1:0] v);
    logic [WL:0] r;
    if (v > MAX_V)      r = {1'b1, MAX_V[WL-1:0]};
    else if (v < MIN_V) r = {1'b1, MIN_V[WL-1:0]};
    else                r = {1'b0, v[WL-1:0]};
    return r;
  endfunction

  logic signed [SW-1:0] shifted;
  logic        [WL:0]   packed_res;

  always_comb begin
    shifted    = round_shift(din);
    packed_res = saturate(shifted);
    clip       = packed_res[WL];
    dout       = packed_res[WL-1:0];
  end

endmodule

// File: rtl/fir_stream_filter.sv
// Parametrised direct-form FIR filter with valid handshake, flush, runtime
// coefficient load, round-half-up and saturation.
//   CLK, RST_N         : clock (rising edge), asynchronous active-low reset
//   x, in_valid        : signed input sample and its accept strobe
//   flush              : clears the delay line and drops results in flight
//   coef_wr, coef_addr,
//   coef_data          : coefficient write port (addresses >= TAPS ignored)
//   y, out_valid, sat  : registered result, its valid, and its clip flag
// Result for a sample is presented two cycles after the cycle it was accepted.
// After reset the coefficients are {1.0, 0, ...}, i.e. a pass-through.
module fir_stream_filter
  import fir_pkg::*;
#(
  parameter int WL   = 8,
  parameter int WF   = 6,
  parameter int TAPS = 3,
  parameter int AW   = 4
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic signed [WL-1:0] x,
  input  logic                 in_valid,
  input  logic                 flush,
  input  logic                 coef_wr,
  input  logic        [AW-1:0] coef_addr,
  input  logic signed [WL-1:0] coef_data,
  output logic signed [WL-1:0] y,
  output logic                 out_valid,
  output logic                 sat
);

  localparam int PW    = 2 * WL;
  localparam int ACC_W = acc_w(WL, TAPS);
  localparam logic signed [WL-1:0] ONE_H = WL'(one_q(WF));

  logic signed [WL-1:0]    d_p0     [TAPS];
  logic signed [WL-1:0]    h        [TAPS];
  logic signed [WL-1:0]    src      [TAPS];
  logic signed [PW-1:0]    prod_nxt [TAPS];
  logic signed [PW-1:0]    prod_p1  [TAPS];
  logic                    vld_p1;
  logic signed [ACC_W-1:0] acc_p1;
  logic signed [WL-1:0]    y_nxt;
  logic                    clip_nxt;

  // Next delay-line contents on an accept. A concurrent flush empties the old
  // taps, so the line becomes {x, 0, ..., 0}. Products are formed from these
  // next contents with the coefficients currently held, which is why a write
  // in the same cycle only affects later samples.
  always_comb begin
    src[0] = x;
    for (int k = 1; k < TAPS; k++)
      src[k] = flush ? '0 : d_p0[k-1];
    for (int k = 0; k < TAPS; k++)
      prod_nxt[k] = PW'(src[k]) * PW'(h[k]);
  end

  // ---- Stage 0/1 boundary: delay line, coefficients, registered products ----
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int k = 0; k < TAPS; k++) begin
        d_p0[k]    <= '0;
        prod_p1[k] <= '0;
        h[k]       <= (k == 0) ? ONE_H : '0;
      end
      vld_p1 <= 1'b0;
    end else begin
      for (int k = 0; k < TAPS; k++) begin
        if (in_valid) begin
          d_p0[k]    <= src[k];
          prod_p1[k] <= prod_nxt[k];
        end else if (flush) begin
          d_p0[k] <= '0;
        end
        // Index compare against k means out-of-range addresses match nothing.
        if (coef_wr && (coef_addr == AW'(k)))
          h[k] <= coef_data;
      end
      vld_p1 <= in_valid;
    end
  end

  always_comb begin
    acc_p1 = '0;
    for (int k = 0; k < TAPS; k++)
      acc_p1 = acc_p1 + ACC_W'(prod_p1[k]);
  end

  fx_round_sat #(
    .IW (ACC_W),
    .WF (WF),
    .WL (WL)
  ) u_round_sat (
    .din  (acc_p1),
    .dout (y_nxt),
    .clip (clip_nxt)
  );

  // ---- Stage 1/2 boundary: requantised output register ----
  // A flush drops the result currently in stage 1; y and sat hold otherwise.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      y         <= '0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= vld_p1 && !flush;
      if (vld_p1 && !flush) begin
        y   <= y_nxt;
        sat <= clip_nxt;
      end
    end
  end

endmodule
